wt_dcache_miss_rsp: RTL

Single-MSHR miss responder that serves the miss-request interface of the write-through L1 dcache read controllers. It sits between the controllers and the memory/L1.5 adapter.
- Arbitrates round-robin among `NumPorts` requesters and acks one miss at a time.
- Replays requests that collide with the outstanding cacheline, and forwards the miss to memory.
- On return, signals completion and refills the selected way.

---
 rtl/wt_dcache_miss_rsp_pkg.sv | 32 +++
 rtl/wt_dcache_miss_rsp_if.sv | 51 +++++
 rtl/wt_dcache_miss_rsp_arb.sv | 42 ++++
 rtl/wt_dcache_miss_rsp.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/wt_dcache_miss_rsp_pkg.sv
// rtl/wt_dcache_miss_rsp_pkg.sv - shared cache geometry, MSHR record and miss FSM states
package wt_cache_pkg;

  localparam int unsigned PLEN                = 32;
  localparam int unsigned CACHE_ID_WIDTH      = 3;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 7;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned DCACHE_LINE_WIDTH   = 8 << DCACHE_OFFSET_WIDTH;
  localparam int unsigned PORT_ID_WIDTH       = 4;
  localparam int unsigned REPL_CNT_WIDTH      = $clog2(DCACHE_SET_ASSOC);

  localparam logic [2:0] CL_SIZE = 3'b111;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_ISSUE,
    MR_WAIT
  } miss_rsp_state_e;

  typedef struct packed {
    logic [PLEN-1:0]             paddr;
    logic [2:0]                  size;
    logic [CACHE_ID_WIDTH-1:0]   id;
    logic                        nc;
    logic [DCACHE_SET_ASSOC-1:0] way;
    logic [PORT_ID_WIDTH-1:0]    port;
  } mshr_t;

endpackage

// File: rtl/wt_dcache_miss_rsp_if.sv
// rtl/wt_dcache_miss_rsp_if.sv - miss request, memory request/return and refill bundle
interface wt_dcache_miss_rsp_if
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts = 2
);

  logic [NumPorts-1:0]         miss_req_i;
  logic [NumPorts-1:0]         miss_ack_o;
  logic [NumPorts-1:0]         miss_replay_o;
  logic [NumPorts-1:0]         miss_rtrn_vld_o;
  logic [PLEN-1:0]             miss_paddr_i    [NumPorts];
  logic [NumPorts-1:0]         miss_nc_i;
  logic [2:0]                  miss_size_i     [NumPorts];
  logic [CACHE_ID_WIDTH-1:0]   miss_id_i       [NumPorts];
  logic [DCACHE_SET_ASSOC-1:0] miss_vld_bits_i [NumPorts];

  logic                         mem_req_o;
  logic                         mem_ack_i;
  logic [PLEN-1:0]              mem_paddr_o;
  logic [2:0]                   mem_size_o;
  logic                         mem_nc_o;
  logic [CACHE_ID_WIDTH-1:0]    mem_tid_o;
  logic [DCACHE_SET_ASSOC-1:0]  mem_way_o;
  logic                         mem_rtrn_vld_i;
  logic [CACHE_ID_WIDTH-1:0]    mem_rtrn_tid_i;
  logic [DCACHE_LINE_WIDTH-1:0] mem_rtrn_data_i;

  logic                           wr_cl_vld_o;
  logic [DCACHE_TAG_WIDTH-1:0]    wr_cl_tag_o;
  logic [DCACHE_CL_IDX_WIDTH-1:0] wr_cl_idx_o;
  logic [DCACHE_SET_ASSOC-1:0]    wr_cl_way_o;
  logic [DCACHE_LINE_WIDTH-1:0]   wr_cl_data_o;

  modport master (
    output miss_req_i, miss_paddr_i, miss_nc_i, miss_size_i, miss_id_i, miss_vld_bits_i,
    output mem_ack_i, mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_data_i,
    input  miss_ack_o, miss_replay_o, miss_rtrn_vld_o,
    input  mem_req_o, mem_paddr_o, mem_size_o, mem_nc_o, mem_tid_o, mem_way_o,
    input  wr_cl_vld_o, wr_cl_tag_o, wr_cl_idx_o, wr_cl_way_o, wr_cl_data_o
  );

  modport slave (
    input  miss_req_i, miss_paddr_i, miss_nc_i, miss_size_i, miss_id_i, miss_vld_bits_i,
    input  mem_ack_i, mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_data_i,
    output miss_ack_o, miss_replay_o, miss_rtrn_vld_o,
    output mem_req_o, mem_paddr_o, mem_size_o, mem_nc_o, mem_tid_o, mem_way_o,
    output wr_cl_vld_o, wr_cl_tag_o, wr_cl_idx_o, wr_cl_way_o, wr_cl_data_o
  );

endinterface

// File: rtl/wt_dcache_miss_rsp_arb.sv
// rtl/wt_dcache_miss_rsp_arb.sv - round-robin one-hot arbiter with its own pointer register
module rr_arb_onehot #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] ptr_q;
  int unsigned     cand;
  logic            found;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    gnt   = '0;
    idx   = ptr_q;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_q) + k) % N;
      if (!found && req[cand[IdxW-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IdxW-1:0]]   = 1'b1;
        idx                   = cand[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (adv && |req) begin
      ptr_q <= (32'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/wt_dcache_miss_rsp.sv
// rtl/wt_dcache_miss_rsp.sv - single-MSHR miss responder: arbitrate, replay collisions, issue, refill
module wt_dcache_miss_rsp
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned ArianeCfg = 0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  input logic                 cache_en_i,
  wt_dcache_miss_rsp_if.slave bus
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  if (ArianeCfg != 0) begin : g_cfg_passthru
  end

  function automatic logic [DCACHE_SET_ASSOC-1:0] first_zero_oh(
    input logic [DCACHE_SET_ASSOC-1:0] vld
  );
    logic [DCACHE_SET_ASSOC-1:0] oh;
    oh = '0;
    for (int i = int'(DCACHE_SET_ASSOC) - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  miss_rsp_state_e             state_q, state_d;
  mshr_t                       mshr_q, mshr_d;
  logic [REPL_CNT_WIDTH-1:0]   repl_q, repl_d;
  logic [NumPorts-1:0]         gnt;
  logic [IdxW-1:0]             win;
  logic [DCACHE_SET_ASSOC-1:0] free_oh;
  logic                        rtrn_hit;

  rr_arb_onehot #(.N(NumPorts)) u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req (bus.miss_req_i),
    .adv (state_q == MR_IDLE && !rst_i),
    .gnt (gnt),
    .idx (win)
  );

  assign free_oh  = first_zero_oh(bus.miss_vld_bits_i[win]);
  assign rtrn_hit = bus.mem_rtrn_vld_i && (bus.mem_rtrn_tid_i == mshr_q.id);

  always_comb begin
    state_d             = state_q;
    mshr_d              = mshr_q;
    repl_d              = repl_q;
    bus.miss_ack_o      = '0;
    bus.miss_replay_o   = '0;
    bus.miss_rtrn_vld_o = '0;
    bus.mem_req_o       = 1'b0;
    bus.mem_paddr_o     = '0;
    bus.mem_size_o      = '0;
    bus.mem_nc_o        = 1'b0;
    bus.mem_tid_o       = '0;
    bus.mem_way_o       = '0;
    bus.wr_cl_vld_o     = 1'b0;
    bus.wr_cl_tag_o     = '0;
    bus.wr_cl_idx_o     = '0;
    bus.wr_cl_way_o     = '0;
    bus.wr_cl_data_o    = '0;

    unique case (state_q)
      MR_IDLE: begin
        if (|bus.miss_req_i && !rst_i) begin
          bus.miss_ack_o = gnt;
          mshr_d.paddr   = bus.miss_paddr_i[win];
          mshr_d.size    = bus.miss_size_i[win];
          mshr_d.id      = bus.miss_id_i[win];
          mshr_d.nc      = bus.miss_nc_i[win] | ~cache_en_i;
          mshr_d.port    = PORT_ID_WIDTH'(win);
          // A full set evicts the way named by the rotating counter.
          if (free_oh == '0) begin
            mshr_d.way = DCACHE_SET_ASSOC'(1) << repl_q;
            repl_d     = repl_q + 1'b1;
          end else begin
            mshr_d.way = free_oh;
          end
          state_d = MR_ISSUE;
        end
      end
      MR_ISSUE: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_paddr_o = mshr_q.nc ? mshr_q.paddr :
                          {mshr_q.paddr[PLEN-1:DCACHE_OFFSET_WIDTH], {DCACHE_OFFSET_WIDTH{1'b0}}};
        bus.mem_size_o  = mshr_q.nc ? mshr_q.size : CL_SIZE;
        bus.mem_nc_o    = mshr_q.nc;
        bus.mem_tid_o   = mshr_q.id;
        bus.mem_way_o   = mshr_q.way;
        if (bus.mem_ack_i) state_d = MR_WAIT;
      end
      MR_WAIT: begin
        if (rtrn_hit) begin
          for (int p = 0; p < int'(NumPorts); p++) begin
            if (mshr_q.port == PORT_ID_WIDTH'(p)) bus.miss_rtrn_vld_o[p] = 1'b1;
          end
          if (!mshr_q.nc) begin
            bus.wr_cl_vld_o  = 1'b1;
            bus.wr_cl_tag_o  = mshr_q.paddr[PLEN-1:DCACHE_INDEX_WIDTH];
            bus.wr_cl_idx_o  = mshr_q.paddr[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
            bus.wr_cl_way_o  = mshr_q.way;
            bus.wr_cl_data_o = bus.mem_rtrn_data_i;
          end
          state_d = MR_IDLE;
        end
      end
      default: state_d = MR_IDLE;
    endcase

    // Requests hitting the line already in flight are told to retry.
    if (state_q != MR_IDLE) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (bus.miss_req_i[p] &&
            bus.miss_paddr_i[p][PLEN-1:DCACHE_OFFSET_WIDTH] == mshr_q.paddr[PLEN-1:DCACHE_OFFSET_WIDTH]) begin
          bus.miss_replay_o[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MR_IDLE;
      mshr_q  <= '0;
      repl_q  <= '0;
    end else begin
      state_q <= state_d;
      mshr_q  <= mshr_d;
      repl_q  <= repl_d;
    end
  end

endmodule
